// File: rtl/key_mixer_pkg.sv
// Shared defaults for the RC5 key-expansion front end: word/key geometry,
// magic constants and the derived address widths.
package key_mixer_pkg;

  localparam int W_DEFAULT        = 32;
  localparam int U_DEFAULT        = 4;
  localparam int B_DEFAULT        = 16;
  localparam int R_DEFAULT        = 12;
  localparam int T_DEFAULT        = 2 * (R_DEFAULT + 1);
  localparam int C_DEFAULT        = B_DEFAULT / U_DEFAULT;
  localparam int B_LENGTH_DEFAULT = $clog2(B_DEFAULT);
  localparam int C_LENGTH_DEFAULT = $clog2(C_DEFAULT);
  localparam int T_LENGTH_DEFAULT = $clog2(T_DEFAULT);

  localparam logic [31:0] P_PROD     = 32'hB7E15163;
  localparam logic [31:0] Q_PROD     = 32'h9E3779B9;
  localparam logic [31:0] QW_DEFAULT = 32'd5;
  localparam logic [31:0] PW_DEFAULT = 32'd10;

  // Next L word: shift the previous word up a byte and append the key byte.
  function automatic logic [W_DEFAULT-1:0] shift_in_byte(input logic [W_DEFAULT-1:0] word,
                                                         input logic [7:0]            key_byte);
    return (word << 8) | W_DEFAULT'(key_byte);
  endfunction

endpackage

// File: rtl/key_mixer_s_init.sv
// S-table progression engine: write counter, Q adder and S_done flag.
// KEYMIXER_PW_INIT_EN: start at index 0 and seed S[0] with pW.
module key_mixer_s_init
  import key_mixer_pkg::*;
#(
  parameter int               w        = W_DEFAULT,
  parameter int               t        = T_DEFAULT,
  parameter int               t_length = T_LENGTH_DEFAULT,
`ifdef KEYMIXER_PW_INIT_EN
  parameter logic [w-1:0]     pW       = w'(PW_DEFAULT),
`endif
  parameter logic [w-1:0]     qW       = w'(QW_DEFAULT)
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic [w-1:0]        S_sub_i,
  output logic [t_length-1:0] S_address,
  output logic [w-1:0]        S_sub_i_prima,
  output logic                S_done
);

`ifdef KEYMIXER_PW_INIT_EN
  localparam logic [t_length-1:0] ADDR_START = t_length'(0);
`else
  localparam logic [t_length-1:0] ADDR_START = t_length'(1);
`endif
  localparam logic [t_length-1:0] ADDR_LAST = t_length'(t - 1);

  logic [t_length-1:0] addr_r;
  logic                done_r;

  // Walk the write index up to t-1, then latch done and freeze.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      addr_r <= ADDR_START;
      done_r <= 1'b0;
    end else if (!done_r) begin
      if (addr_r == ADDR_LAST) begin
        done_r <= 1'b1;
      end else begin
        addr_r <= addr_r + t_length'(1);
      end
    end
  end

  // Next S entry; index 0 only occurs on the very first cycle when seeding is on.
  always_comb begin
    S_sub_i_prima = S_sub_i + qW;
`ifdef KEYMIXER_PW_INIT_EN
    if (addr_r == t_length'(0)) begin
      S_sub_i_prima = pW;
    end else begin
      S_sub_i_prima = S_sub_i + qW;
    end
`endif
  end

  assign S_address = addr_r;
  assign S_done    = done_r;

endmodule

// File: rtl/key_mixer.sv
// RC5 key-expansion front end: loads key bytes into L words and fills the S
// table concurrently. KEYMIXER_PW_INIT_EN adds pW and seeds S[0] internally.
module key_mixer
  import key_mixer_pkg::*;
#(
  parameter int               b        = B_DEFAULT,
  parameter int               b_length = B_LENGTH_DEFAULT,
  parameter int               w        = W_DEFAULT,
  parameter int               u        = U_DEFAULT,
  parameter int               c_length = C_LENGTH_DEFAULT,
  parameter int               t        = T_DEFAULT,
  parameter int               t_length = T_LENGTH_DEFAULT,
`ifdef KEYMIXER_PW_INIT_EN
  parameter logic [w-1:0]     pW       = w'(PW_DEFAULT),
`endif
  parameter logic [w-1:0]     qW       = w'(QW_DEFAULT)
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic [7:0]          key_sub_i,
  output logic [b_length-1:0] key_address,
  input  logic [w-1:0]        L_sub_i,
  output logic [c_length-1:0] L_address,
  output logic [w-1:0]        L_sub_i_prima,
  output logic                L_done,
  input  logic [w-1:0]        S_sub_i,
  output logic [t_length-1:0] S_address,
  output logic [w-1:0]        S_sub_i_prima,
  output logic                S_done
);

  localparam int U_SHIFT = $clog2(u);

  logic [b_length-1:0] key_addr_r;
  logic                l_done_r;

  // Key bytes are consumed from the top down so each word ends little-endian.
  always_ff @(posedge clk1) begin
    if (!rst) begin
      key_addr_r <= b_length'(b - 1);
      l_done_r   <= 1'b0;
    end else if (!l_done_r) begin
      if (key_addr_r == b_length'(0)) begin
        l_done_r <= 1'b1;
      end else begin
        key_addr_r <= key_addr_r - b_length'(1);
      end
    end
  end

  assign key_address   = key_addr_r;
  assign L_address     = c_length'(key_addr_r >> U_SHIFT);
  assign L_sub_i_prima = (L_sub_i << 8) | w'(key_sub_i);
  assign L_done        = l_done_r;

  key_mixer_s_init #(
    .w        (w),
    .t        (t),
    .t_length (t_length),
`ifdef KEYMIXER_PW_INIT_EN
    .pW       (pW),
`endif
    .qW       (qW)
  ) u_s_init (
    .clk1          (clk1),
    .rst           (rst),
    .S_sub_i       (S_sub_i),
    .S_address     (S_address),
    .S_sub_i_prima (S_sub_i_prima),
    .S_done        (S_done)
  );

endmodule

// File: tb/tb_key_mixer.sv
// Directed bench for key_mixer with behavioural key ROM, L RAM and S RAM.
module tb_key_mixer;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b0;
  logic [7:0]  key_sub_i;
  logic [3:0]  key_address;
  logic [31:0] L_sub_i;
  logic [1:0]  L_address;
  logic [31:0] L_sub_i_prima;
  logic        L_done;
  logic [31:0] S_sub_i;
  logic [4:0]  S_address;
  logic [31:0] S_sub_i_prima;
  logic        S_done;

  logic [3:0]  p_key_address;
  logic [1:0]  p_L_address;
  logic [31:0] p_L_sub_i_prima;
  logic        p_L_done;
  logic [4:0]  p_S_address;
  logic [31:0] p_S_sub_i_prima;
  logic        p_S_done;

  logic [127:0] key = 128'hFFFEEEE58684FFF05FFE493853000434;
  logic [7:0]   key_rom [16];
  logic [31:0]  l_mem   [4];
  logic [31:0]  s_mem   [26];
  logic         scrub = 1'b0;
  int           l_wr_cnt = 0;
  int           s_wr_cnt = 0;
  int           s0_wr_cnt = 0;
  int           n_assert = 0;
  int           n_fail = 0;

`ifdef KEYMIXER_PW_INIT_EN
  localparam int          S_LAT   = 26;
  localparam logic [4:0]  S_RST   = 5'd0;
  localparam int          S0_WR   = 1;
  localparam logic [31:0] S_PRIMA_RST = 32'd10;
`else
  localparam int          S_LAT   = 25;
  localparam logic [4:0]  S_RST   = 5'd1;
  localparam int          S0_WR   = 0;
  localparam logic [31:0] S_PRIMA_RST = 32'd15;
`endif

  always #5 clk1 = ~clk1;

  key_mixer dut (
    .clk1(clk1), .rst(rst), .key_sub_i(key_sub_i), .key_address(key_address),
    .L_sub_i(L_sub_i), .L_address(L_address), .L_sub_i_prima(L_sub_i_prima), .L_done(L_done),
    .S_sub_i(S_sub_i), .S_address(S_address), .S_sub_i_prima(S_sub_i_prima), .S_done(S_done)
  );

  key_mixer #(.qW(32'h9E3779B9)) dut_prod (
    .clk1(clk1), .rst(1'b1), .key_sub_i(8'h00), .key_address(p_key_address),
    .L_sub_i(32'h0000_0000), .L_address(p_L_address), .L_sub_i_prima(p_L_sub_i_prima), .L_done(p_L_done),
    .S_sub_i(32'hFFFF_FFFF), .S_address(p_S_address), .S_sub_i_prima(p_S_sub_i_prima), .S_done(p_S_done)
  );

  always_comb begin
    key_sub_i = key_rom[key_address];
    L_sub_i   = l_mem[L_address];
    S_sub_i   = (S_address == 5'd0) ? 32'h0000_0000 : s_mem[S_address - 5'd1];
  end

  // Memory model: scrub loads garbage, otherwise write while done is low.
  always @(posedge clk1) begin
    if (scrub) begin
      for (int i = 0; i < 4; i++) l_mem[i] <= 32'hDEAD_0000 + 32'(i);
      l_mem[3] <= 32'h1234_5678;
      for (int i = 0; i < 26; i++) s_mem[i] <= 32'hBAD0_0000 + 32'(i);
`ifndef KEYMIXER_PW_INIT_EN
      s_mem[0] <= 32'd10;
`endif
      l_wr_cnt  <= 0;
      s_wr_cnt  <= 0;
      s0_wr_cnt <= 0;
    end else if (rst) begin
      if (!L_done) begin
        l_mem[L_address] <= L_sub_i_prima;
        l_wr_cnt <= l_wr_cnt + 1;
      end
      if (!S_done) begin
        s_mem[S_address] <= S_sub_i_prima;
        s_wr_cnt <= s_wr_cnt + 1;
        if (S_address == 5'd0) s0_wr_cnt <= s0_wr_cnt + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_tables();
    check("L0", l_mem[0], 32'h5300_0434);
    check("L1", l_mem[1], 32'h5FFE_4938);
    check("L2", l_mem[2], 32'h8684_FFF0);
    check("L3", l_mem[3], 32'hFFFE_EEE5);
    for (int i = 0; i < 26; i++) check($sformatf("S%0d", i), s_mem[i], 32'd10 + 32'd5 * 32'(i));
    check("S25", s_mem[25], 32'd135);
    check("s0_writes", 32'(s0_wr_cnt), 32'(S0_WR));
  endtask

  task automatic run_edges(input int n, input int first_e);
    for (int e = first_e; e < first_e + n; e++) begin
      @(posedge clk1);
      #1;
      if (e == 1)         check("key_addr_e1", 32'(key_address), 32'd14);
      if (e == 15)        check("L_done_e15", 32'(L_done), 32'd0);
      if (e == 16)        check("L_done_e16", 32'(L_done), 32'd1);
      if (e == S_LAT - 1) check("S_done_pre", 32'(S_done), 32'd0);
      if (e == S_LAT)     check("S_done_lat", 32'(S_done), 32'd1);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) key_rom[i] = key[8*i +: 8];
    scrub = 1'b1;
    rst   = 1'b0;
    @(posedge clk1);
    @(negedge clk1);
    scrub = 1'b0;
    @(posedge clk1);
    @(negedge clk1);

    check("rst_key_addr", 32'(key_address), 32'd15);
    check("rst_L_addr", 32'(L_address), 32'd3);
    check("rst_L_done", 32'(L_done), 32'd0);
    check("rst_S_addr", 32'(S_address), 32'(S_RST));
    check("rst_S_done", 32'(S_done), 32'd0);
    check("rst_L_prima", L_sub_i_prima, 32'h3456_78FF);
    check("rst_S_prima", S_sub_i_prima, S_PRIMA_RST);

    rst = 1'b1;
    run_edges(40, 1);
    check_tables();
    check("l_writes", 32'(l_wr_cnt), 32'd16);
    check("s_writes", 32'(s_wr_cnt), 32'(S_LAT));
    check("idle_key_addr", 32'(key_address), 32'd0);
    check("idle_L_addr", 32'(L_address), 32'd0);
    check("idle_S_addr", 32'(S_address), 32'd25);
    check("idle_L_done", 32'(L_done), 32'd1);
    check("idle_S_done", 32'(S_done), 32'd1);
    check("prod_carry", p_S_sub_i_prima, 32'h9E37_79B8);

    @(negedge clk1);
    scrub = 1'b1;
    rst   = 1'b0;
    @(negedge clk1);
    scrub = 1'b0;
    rst   = 1'b1;
    run_edges(6, 100);
    @(negedge clk1);
    rst = 1'b0;
    @(posedge clk1);
    #1;
    check("mid_rst_key_addr", 32'(key_address), 32'd15);
    check("mid_rst_S_addr", 32'(S_address), 32'(S_RST));
    check("mid_rst_L_done", 32'(L_done), 32'd0);
    @(negedge clk1);
    rst = 1'b1;
    run_edges(40, 1);
    check_tables();
    check("mid_l_writes", 32'(l_wr_cnt), 32'd22);
    check("mid_s_writes", 32'(s_wr_cnt), 32'(6 + S_LAT));
    check("mid_S_addr", 32'(S_address), 32'd25);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/key_mixer.md
Name: key_mixer

Overview:
- Key-expansion front end of the RC5 cipher core (w/r/b variant).
- Phase L converts the b-byte secret key into c = b/u little-endian words in external L memory.
- Phase S fills the external S table with the arithmetic progression S[i] = S[i-1] + Q.
- Pure address/datapath engine: reads and writes the key ROM, L RAM and S RAM through address ports; holds no key storage itself.

Parameters:
- b, 16, key length in bytes
- b_length, 4, key address width, = clog2(b)
- w, 32, word width in bits
- u, 4, bytes per word; w must equal 8*u
- c_length, 2, L address width, = clog2(b/u)
- t, 26, S table size, = 2*(r+1) with r=12
- t_length, 5, S address width, = clog2(t)
- qW, 5, S increment constant (production value 32'h9E3779B9)

Ports:
- clk1, in, 1, single system clock, rising edge
- rst, in, 1, synchronous active-low reset
- key_sub_i, in, 8, key byte K[key_address], combinational return from key ROM
- key_address, out, b_length, key byte index
- L_sub_i, in, w, current L[L_address], combinational return
- L_address, out, c_length, L word index (read and write)
- L_sub_i_prima, out, w, new value for L[L_address]
- L_done, out, 1, phase L complete
- S_sub_i, in, w, S[S_address-1], combinational return
- S_address, out, t_length, S write index
- S_sub_i_prima, out, w, new value for S[S_address]
- S_done, out, 1, phase S complete

Behaviour:
- Reset (rst==0 at clk1 edge): key_address=b-1, L_address=(b-1)/u, L_done=0, S_address=1, S_done=0. Reset mid-operation restarts both phases on the next cycle.
- Phases L and S run concurrently and independently, both starting on the first edge with rst==1.
- Phase L, each cycle while L_done==0:
  - L_sub_i_prima = {L_sub_i[w-9:0], key_sub_i}, i.e. (L<<8)+K modulo 2^w, combinational.
  - External RAM writes L_sub_i_prima to L[L_address] on that edge; L_done==0 is the write enable.
  - L_address is always key_address >> log2(u).
  - key_address decrements each cycle. After the cycle with key_address==0, L_done rises and holds; addresses freeze at 0 with no wrap.
  - Latency: L_done high b edges after reset release.
  - Because 8*u==w, every L word is fully overwritten; L RAM needs no pre-clear.
- Phase S, each cycle while S_done==0:
  - S_sub_i_prima = S_sub_i + qW modulo 2^w; carry discarded.
  - External RAM writes it to S[S_address]; S_done==0 is the write enable.
  - S_address increments. After writing S_address==t-1, S_done rises and holds; S_address freezes at t-1.
  - Latency: t-1 edges.
- While a done flag is high, its prima output still tracks its inputs combinationally, but no write occurs.
- All registered state lives on clk1 only.

Optional Feature:
- Macro KEYMIXER_PW_INIT_EN.
- Defined: adds parameter pW (default 10; production 32'hB7E15163). S_address resets to 0, and the first S cycle drives S_sub_i_prima=pW. S phase takes t cycles.
- Undefined: S[0] must be preloaded externally with P before reset release. S_address starts at 1.

Decomposition:
- Shared package key_mixer_pkg: defaults for w, u, b, r, t, c, P/Q constants, and derived clog2 widths.
- One natural sub-module: key_mixer_s_init (S counter, adder, S_done). The L loader stays in the top level.

Test Plan:
- Key 128'hFFFEEEE58684FFF05FFE493853000434, K[i]=key[8i+7:8i], L RAM initialised to garbage -> after 16 cycles L_done=1 and L = {0x53000434, 0x5FFE4938, 0x8684FFF0, 0xFFFEEEE5}.
- S[0]=10, qW=5, macro off -> S[i]=10+5i, S[25]=135; S_done=1 exactly 25 edges after reset release; no write at index 0.
- Run 40 cycles -> after the done flags rise, no further writes occur; addresses are stable at L 0 / key 0 and S 25.
- Assert rst low for one cycle at cycle 7 -> key_address returns to 15, S_address to 1; final L/S contents identical to the first test.
- qW=32'h9E3779B9, S_sub_i=32'hFFFFFFFF -> S_sub_i_prima=32'h9E3779B8 (carry dropped).
- KEYMIXER_PW_INIT_EN defined, pW=10 -> S[0]=10 written in the first cycle, S_done after 26 edges, S[25]=135.
